bit_pattern: RTL and testbench
==============================

BIT_PATTERN -- requirements
Module: bit_pattern

Interface
REQ-001 The module SHALL have parameter PAT_WIDTH, default 4, meaning the pattern length in bits (legal range 2..32).
REQ-002 The module SHALL have parameter PATTERN, default 4'b1011, PAT_WIDTH bits wide, meaning the target sequence with its MSB as the first bit received.
REQ-003 The module SHALL have parameter OVERLAP, default 1, meaning 1 allows overlapping matches and 0 allows only non-overlapping matches.
REQ-004 The module SHALL have parameter CNT_WIDTH, default 16, meaning the width of the match counter.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The module SHALL have port data, input, 1 bit: serial input, sampled once per rising clk edge.
REQ-008 The module SHALL have port detect, output, 1 bit: registered one-cycle match pulse.
REQ-009 The module SHALL have port match_count, output, CNT_WIDTH bits: number of matches since reset; present only when BIT_PATTERN_COUNT_EN is defined.

Function
REQ-010 The module SHALL shift data into a PAT_WIDTH-bit history register on every rising clk edge while rst is low, with the newest bit in the LSB.
REQ-011 The module SHALL keep a fill counter of valid history bits, incremented per sample and saturating at PAT_WIDTH.
REQ-012 The module SHALL declare a match on an edge when the fill count before that edge is at least PAT_WIDTH-1 and {history[PAT_WIDTH-2:0], data} equals PATTERN.
REQ-013 The module SHALL set detect to 1 on the rising edge that samples the final pattern bit, with zero additional latency.
REQ-014 The module SHALL clear detect on the next rising edge unless that edge is also a match; back-to-back matches therefore hold detect high on consecutive cycles.
REQ-015 With OVERLAP=1, the module SHALL retain history after a match, so input 1011011 produces detect pulses after bits 4 and 7.
REQ-016 With OVERLAP=0, the module SHALL reset the fill count to 0 on a match, so input 1011011 produces only one pulse, after bit 4.
REQ-017 The module SHALL never assert detect with fewer than PAT_WIDTH bits received since reset, or since the last match when OVERLAP=0.
REQ-018 Any data value on the edge of a match SHALL be treated as the final pattern bit; there are no don't-care pattern positions.

Reset
REQ-019 While rst is high, the module SHALL immediately clear the history, fill count, detect and match_count to 0, independent of clk.
REQ-020 On rst deassertion, the module SHALL take its first sample on the first rising clk edge at which rst is low.
REQ-021 If rst is asserted mid-pattern, the module SHALL discard the partial pattern, and no later detect may use pre-reset bits.

Configuration
REQ-022 When the macro BIT_PATTERN_COUNT_EN is defined, the module SHALL provide the match_count port and counter logic.
REQ-023 With BIT_PATTERN_COUNT_EN defined, match_count SHALL increment by 1 on each edge that sets detect, and saturate at all-ones.
REQ-024 When BIT_PATTERN_COUNT_EN is not defined, the module SHALL have no match_count port and no counter logic, with detect behaviour unchanged.

Verification
REQ-025 The bench SHALL check: after reset, send 1,0,1,1 -> detect=1 for exactly the cycle after the 4th-bit edge, and 0 otherwise.
REQ-026 The bench SHALL check: with OVERLAP=1, send 1011011 -> detect pulses after bits 4 and 7, match_count=2.
REQ-027 The bench SHALL check: with OVERLAP=0, send 1011011 -> one pulse after bit 4, match_count=1.
REQ-028 The bench SHALL check: send 1,0,1, pulse rst high asynchronously between edges, then send 1 -> detect stays 0 and match_count=0.
REQ-029 The bench SHALL check: send ten 0s, then ten 1s -> detect never asserts.
REQ-030 The bench SHALL check: with CNT_WIDTH=2, send 10111011101110111011 (five matches) -> match_count saturates at 3.

Source files
------------

// File: rtl/bit_pattern.sv
// bit_pattern: serial detector for a PAT_WIDTH-bit pattern, MSB received first.
// Define BIT_PATTERN_COUNT_EN to add the saturating match_count output.
module bit_pattern #(
  parameter int PAT_WIDTH = 4,
  parameter logic [PAT_WIDTH-1:0] PATTERN = 4'b1011,
  parameter int OVERLAP = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic data,
  output logic detect
`ifdef BIT_PATTERN_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] match_count
`endif
);
  localparam int FW = $clog2(PAT_WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_WIDTH);
  localparam logic [FW-1:0] NEED = FW'(PAT_WIDTH - 1);
  logic [PAT_WIDTH-1:0] history;
  logic [FW-1:0] fill;
  logic match;
  logic unused_oldest;
  // the incoming bit completes the window, so a match is decided on the sampling edge
  assign match = (fill >= NEED) && ({history[PAT_WIDTH-2:0], data} == PATTERN);
  assign unused_oldest = history[PAT_WIDTH-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
      detect  <= 1'b0;
    end else begin
      history <= {history[PAT_WIDTH-2:0], data};
      fill    <= (match && OVERLAP == 0) ? '0 : (fill == FULL ? fill : fill + 1'b1);
      detect  <= match;
    end
  end
`ifdef BIT_PATTERN_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) match_count <= '0;
    else match_count <= (match && !(&match_count)) ? match_count + 1'b1 : match_count;
  end
`endif
endmodule

// File: tb/tb_bit_pattern.sv
// tb_bit_pattern: directed tables plus randomized stimulus against a queue-based model,
// covering overlapping, non-overlapping and narrow-counter configurations.
module tb_bit_pattern;
  localparam bit [3:0] PAT = 4'b1011;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data = 1'b0;
  logic det [3];
  int checks = 0;
  int errors = 0;
`ifdef BIT_PATTERN_COUNT_EN
  logic [15:0] cnt0, cnt1;
  logic [1:0] cnt2;
`endif

  bit q [3][$];
  int mcnt [3];
  bit mexp [3];
  int ov [3] = '{1, 0, 1};
  int cw [3] = '{16, 16, 2};

  typedef struct {
    bit d;
    bit e_ov;
    bit e_nov;
  } vec_t;
  vec_t tv [9];
  logic [8:0] s_d = 9'b101101100;
  logic [8:0] s_o = 9'b000100100;
  logic [8:0] s_n = 9'b000100000;
  logic [19:0] s_sat = 20'b10111011101110111011;

  always #5 clk = ~clk;

  bit_pattern d0 (.clk(clk), .rst(rst), .data(data), .detect(det[0])
`ifdef BIT_PATTERN_COUNT_EN
    , .match_count(cnt0)
`endif
  );
  bit_pattern #(.OVERLAP(0)) d1 (.clk(clk), .rst(rst), .data(data), .detect(det[1])
`ifdef BIT_PATTERN_COUNT_EN
    , .match_count(cnt1)
`endif
  );
  bit_pattern #(.CNT_WIDTH(2)) d2 (.clk(clk), .rst(rst), .data(data), .detect(det[2])
`ifdef BIT_PATTERN_COUNT_EN
    , .match_count(cnt2)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      mcnt[i] = 0;
      mexp[i] = 1'b0;
    end
  endfunction

  // a match is simply "the last four bits kept since reset (or since the last match) equal PAT"
  function automatic void model_step(input bit b);
    for (int i = 0; i < 3; i++) begin
      int n;
      bit ok;
      q[i].push_back(b);
      if (q[i].size() > 4) void'(q[i].pop_front());
      n = q[i].size();
      ok = (n == 4);
      for (int k = 0; k < 4 && ok; k++) if (q[i][k] != PAT[3-k]) ok = 1'b0;
      mexp[i] = ok;
      if (ok) begin
        if (mcnt[i] < (1 << cw[i]) - 1) mcnt[i]++;
        if (ov[i] == 0) q[i].delete();
      end
    end
  endfunction

  task automatic step(input bit b);
    data = b;
    @(posedge clk);
    model_step(b);
    #1;
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 3; i++) chk($sformatf("%s detect[%0d]", tag, i), int'(det[i]), int'(mexp[i]));
`ifdef BIT_PATTERN_COUNT_EN
    chk({tag, " count0"}, int'(cnt0), mcnt[0]);
    chk({tag, " count1"}, int'(cnt1), mcnt[1]);
    chk({tag, " count2"}, int'(cnt2), mcnt[2]);
`endif
  endtask

  task automatic check_clear(input string tag);
    for (int i = 0; i < 3; i++) chk($sformatf("%s detect[%0d]", tag, i), int'(det[i]), 0);
`ifdef BIT_PATTERN_COUNT_EN
    chk({tag, " count0"}, int'(cnt0), 0);
    chk({tag, " count1"}, int'(cnt1), 0);
    chk({tag, " count2"}, int'(cnt2), 0);
`endif
  endtask

  // asserts rst between edges and checks the outputs clear without a clock edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_clear(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 9; i++) tv[i] = '{s_d[8-i], s_o[8-i], s_n[8-i]};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_clear("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step(tv[i].d);
      chk($sformatf("tbl bit%0d ov", i + 1), int'(det[0]), int'(tv[i].e_ov));
      chk($sformatf("tbl bit%0d nov", i + 1), int'(det[1]), int'(tv[i].e_nov));
      chk($sformatf("tbl bit%0d cw2", i + 1), int'(det[2]), int'(tv[i].e_ov));
    end
`ifdef BIT_PATTERN_COUNT_EN
    chk("tbl count ov", int'(cnt0), 2);
    chk("tbl count nov", int'(cnt1), 1);
`endif

    do_reset("pre-abort");
    step(1'b1);
    step(1'b0);
    step(1'b1);
    check_model("partial");
    do_reset("abort");
    step(1'b1);
    for (int i = 0; i < 3; i++) chk($sformatf("abort post detect[%0d]", i), int'(det[i]), 0);

    do_reset("pre-clear");
    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    chk("hit before clear", int'(det[0]), 1);
    do_reset("async clear");

    for (int i = 0; i < 20; i++) begin
      step(i >= 10);
      for (int k = 0; k < 3; k++) chk($sformatf("runs bit%0d detect[%0d]", i, k), int'(det[k]), 0);
    end

    do_reset("pre-sat");
    for (int i = 19; i >= 0; i--) begin
      step(s_sat[i]);
      check_model("sat");
    end
`ifdef BIT_PATTERN_COUNT_EN
    chk("sat count cw2", int'(cnt2), 3);
    chk("sat count cw16", int'(cnt0), 5);
`endif

    do_reset("pre-rand");
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset("rand reset");
      step(1'($urandom_range(0, 1)));
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
